// File: rtl/pipeline_int_ctrl.sv
// Interrupt controller in front of coprocessor 0: synchronizes and edge-detects
// external lines, latches them as pending and sequences request/ack/eret.
module pipeline_int_ctrl #(
    parameter int unsigned N_IRQ     = 8,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0080
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic             i_we,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_data,
    input  logic             i_ack,
    input  logic             i_eret,
    output logic [31:0]      o_data,
    output logic             o_int_req,
    output logic [2:0]       o_irq_id,
    output logic             o_busy
);

    localparam logic [31:0] AddrMask = ADDR_BASE;
    localparam logic [31:0] AddrPend = ADDR_BASE + 32'd4;
    localparam logic [31:0] AddrId   = ADDR_BASE + 32'd8;

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e           state_q;
    logic [N_IRQ-1:0] sync1_q, sync2_q, hist_q;
    logic [N_IRQ-1:0] mask_q, pend_q, pend_d;
    logic [N_IRQ-1:0] irq_edge, active, id_onehot, pend_clr;
    logic [2:0]       sel;
    logic             any_active, cur_active;
    logic             wr_mask, wr_pend;
    logic             unused_data;

    assign unused_data = ^i_data;

    always_comb begin
        irq_edge   = sync2_q & ~hist_q;
        active     = pend_q & mask_q;
        any_active = |active;
        // Scan downward so the lowest active index wins.
        sel = '0;
        for (int k = int'(N_IRQ) - 1; k >= 0; k--) begin
            if (active[k]) sel = 3'(k);
        end
        id_onehot = '0;
        for (int k = 0; k < int'(N_IRQ); k++) begin
            if (o_irq_id == 3'(k)) id_onehot[k] = 1'b1;
        end
        cur_active = |(active & id_onehot);
        wr_mask    = i_we && (i_addr == AddrMask);
        wr_pend    = i_we && (i_addr == AddrPend);
        pend_clr   = (wr_pend ? i_data[N_IRQ-1:0] : '0)
                   | ((state_q == StReq && i_ack) ? id_onehot : '0);
        // A new edge overrides a same-cycle clear.
        pend_d     = (pend_q & ~pend_clr) | irq_edge;
    end

    always_comb begin
        o_data = '0;
        if (i_addr == AddrMask) begin
            o_data[N_IRQ-1:0] = mask_q;
        end else if (i_addr == AddrPend) begin
            o_data[N_IRQ-1:0] = pend_q;
        end else if (i_addr == AddrId) begin
            o_data[31]  = o_busy;
            o_data[2:0] = o_irq_id;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
            mask_q  <= '1;
            pend_q  <= '0;
        end else begin
            sync1_q <= i_irq;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
            pend_q  <= pend_d;
            if (wr_mask) mask_q <= i_data[N_IRQ-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            o_int_req <= 1'b0;
            o_irq_id  <= '0;
            o_busy    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_active) begin
                        o_irq_id  <= sel;
                        o_int_req <= 1'b1;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (i_ack) begin
                        o_int_req <= 1'b0;
                        o_busy    <= 1'b1;
                        state_q   <= StService;
                    end else if (!cur_active) begin
                        // Masked or cleared by software before acceptance.
                        o_int_req <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StService: begin
                    if (i_eret) begin
                        o_busy  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    o_int_req <= 1'b0;
                    o_busy    <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_int_ctrl.sv
// Directed self-checking bench for pipeline_int_ctrl.
module tb_pipeline_int_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0080;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [7:0]  i_irq;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        i_ack;
    logic        i_eret;
    logic [31:0] o_data;
    logic        o_int_req;
    logic [2:0]  o_irq_id;
    logic        o_busy;

    integer checks = 0;
    integer errors = 0;
    logic [31:0] rd;

    pipeline_int_ctrl #(.N_IRQ(8), .ADDR_BASE(BASE)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_irq     (i_irq),
        .i_we      (i_we),
        .i_addr    (i_addr),
        .i_data    (i_data),
        .i_ack     (i_ack),
        .i_eret    (i_eret),
        .o_data    (o_data),
        .o_int_req (o_int_req),
        .o_irq_id  (o_irq_id),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
        i_we = 1'b1; i_addr = addr; i_data = data;
        tick();
        i_we = 1'b0; i_data = '0;
    endtask

    task automatic reg_read(input logic [31:0] addr, output logic [31:0] data);
        i_we = 1'b0; i_addr = addr;
        #1;
        data = o_data;
    endtask

    task automatic pulse_irq(input logic [7:0] lines);
        i_irq = lines;
        tick();
        i_irq = '0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_irq = '0; i_we = 0; i_addr = '0; i_data = '0;
        i_ack = 0; i_eret = 0;
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
        reg_read(BASE, rd);
        checks++; if (rd !== 32'h0000_00ff) begin errors++;
            $display("FAIL reset_mask got %h want 000000ff", rd); end
        reg_read(BASE + 4, rd);
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL reset_pend got %h want 00000000", rd); end
        reg_read(BASE + 8, rd);
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL reset_id got %h want 00000000", rd); end
        checks++; if (o_int_req !== 1'b0 || o_busy !== 1'b0) begin errors++;
            $display("FAIL reset_out got req=%b busy=%b want 0 0", o_int_req, o_busy); end
        reg_write(BASE + 8, 32'h8000_0007);
        reg_read(BASE + 8, rd);
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL id_readonly got %h want 00000000", rd); end
        reg_read(BASE + 12, rd);
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL unmapped_read got %h want 00000000", rd); end
    endtask

    task automatic test_single();
        pulse_irq(8'h08);   // edge 0
        tick(); tick();     // edges 1, 2
        checks++; if (o_int_req !== 1'b0) begin errors++;
            $display("FAIL single_early_req got %b want 0", o_int_req); end
        reg_read(BASE + 4, rd);
        checks++; if (rd !== 32'h08) begin errors++;
            $display("FAIL single_pend got %h want 00000008", rd); end
        tick();             // edge 3
        checks++; if (o_int_req !== 1'b1) begin errors++;
            $display("FAIL single_req got %b want 1", o_int_req); end
        reg_read(BASE + 8, rd);
        checks++; if (rd !== 32'h3) begin errors++;
            $display("FAIL single_id got %h want 00000003", rd); end
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        reg_read(BASE + 4, rd);
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL ack_pend got %h want 00000000", rd); end
        reg_read(BASE + 8, rd);
        checks++; if (rd !== 32'h8000_0003) begin errors++;
            $display("FAIL ack_id got %h want 80000003", rd); end
        checks++; if (o_int_req !== 1'b0 || o_busy !== 1'b1) begin errors++;
            $display("FAIL ack_out got req=%b busy=%b want 0 1", o_int_req, o_busy); end
        i_eret = 1'b1; tick(); i_eret = 1'b0;
        checks++; if (o_busy !== 1'b0) begin errors++;
            $display("FAIL eret_busy got %b want 0", o_busy); end
    endtask

    task automatic test_back_to_back();
        pulse_irq(8'h22);
        repeat (3) tick();
        checks++; if (o_int_req !== 1'b1 || o_irq_id !== 3'd1) begin errors++;
            $display("FAIL b2b_first got req=%b id=%0d want 1 1", o_int_req, o_irq_id); end
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        reg_read(BASE + 4, rd);
        checks++; if (rd !== 32'h20) begin errors++;
            $display("FAIL b2b_pend got %h want 00000020", rd); end
        tick(); tick();
        checks++; if (o_int_req !== 1'b0 || o_busy !== 1'b1) begin errors++;
            $display("FAIL b2b_service got req=%b busy=%b want 0 1", o_int_req, o_busy); end
        i_eret = 1'b1; tick(); i_eret = 1'b0;
        checks++; if (o_int_req !== 1'b0 || o_busy !== 1'b0 || o_irq_id !== 3'd1) begin
            errors++;
            $display("FAIL b2b_gap got req=%b busy=%b id=%0d want 0 0 1",
                     o_int_req, o_busy, o_irq_id); end
        tick();
        checks++; if (o_int_req !== 1'b1 || o_irq_id !== 3'd5) begin errors++;
            $display("FAIL b2b_second got req=%b id=%0d want 1 5", o_int_req, o_irq_id); end
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        i_eret = 1'b1; tick(); i_eret = 1'b0;
    endtask

    task automatic test_mask();
        reg_write(BASE, 32'hFD);
        pulse_irq(8'h02);
        repeat (4) tick();
        reg_read(BASE + 4, rd);
        checks++; if (rd !== 32'h02) begin errors++;
            $display("FAIL mask_pend got %h want 00000002", rd); end
        checks++; if (o_int_req !== 1'b0) begin errors++;
            $display("FAIL mask_noreq got %b want 0", o_int_req); end
        reg_write(BASE, 32'hFF);
        tick();
        checks++; if (o_int_req !== 1'b1 || o_irq_id !== 3'd1) begin errors++;
            $display("FAIL unmask_req got req=%b id=%0d want 1 1", o_int_req, o_irq_id); end
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        i_eret = 1'b1; tick(); i_eret = 1'b0;
    endtask

    task automatic test_withdraw();
        pulse_irq(8'h04);
        repeat (3) tick();
        checks++; if (o_int_req !== 1'b1 || o_irq_id !== 3'd2) begin errors++;
            $display("FAIL wd_req got req=%b id=%0d want 1 2", o_int_req, o_irq_id); end
        reg_write(BASE + 4, 32'h04);
        reg_read(BASE + 4, rd);
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL wd_pend got %h want 00000000", rd); end
        tick();
        checks++; if (o_int_req !== 1'b0 || o_busy !== 1'b0) begin errors++;
            $display("FAIL wd_drop got req=%b busy=%b want 0 0", o_int_req, o_busy); end
        tick();
        checks++; if (o_int_req !== 1'b0) begin errors++;
            $display("FAIL wd_idle got %b want 0", o_int_req); end
    endtask

    task automatic test_w1c_race();
        reg_write(BASE, 32'h00);
        pulse_irq(8'h10);
        repeat (3) tick();
        reg_read(BASE + 4, rd);
        checks++; if (rd !== 32'h10) begin errors++;
            $display("FAIL race_pre got %h want 00000010", rd); end
        i_irq = 8'h10;
        tick(); tick();     // s2 now high, edge[4] active this cycle
        reg_write(BASE + 4, 32'h10);
        reg_read(BASE + 4, rd);
        checks++; if (rd !== 32'h10) begin errors++;
            $display("FAIL race_setwins got %h want 00000010", rd); end
        reg_write(BASE + 4, 32'h10);
        reg_read(BASE + 4, rd);
        checks++; if (rd !== 32'h0) begin errors++;
            $display("FAIL w1c_clear got %h want 00000000", rd); end
        i_irq = '0;
        tick();
    endtask

    task automatic test_reset_midop();
        reg_write(BASE, 32'hFE);
        pulse_irq(8'h02);
        repeat (3) tick();
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        checks++; if (o_busy !== 1'b1 || o_irq_id !== 3'd1) begin errors++;
            $display("FAIL mid_service got busy=%b id=%0d want 1 1", o_busy, o_irq_id); end
        #1 i_rst_n = 1'b0;
        #1;
        checks++; if (o_busy !== 1'b0 || o_int_req !== 1'b0 || o_irq_id !== 3'd0) begin
            errors++;
            $display("FAIL mid_reset got busy=%b req=%b id=%0d want 0 0 0",
                     o_busy, o_int_req, o_irq_id); end
        reg_read(BASE, rd);
        checks++; if (rd !== 32'hFF) begin errors++;
            $display("FAIL mid_mask got %h want 000000ff", rd); end
        tick();
        i_rst_n = 1'b1;
        repeat (4) tick();
        checks++; if (o_int_req !== 1'b0) begin errors++;
            $display("FAIL post_reset got %b want 0", o_int_req); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_withdraw();
        test_w1c_race();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_int_ctrl.md
Name: pipeline_int_ctrl

Overview:
Interrupt controller sitting in front of the pipeline coprocessor 0.
- Collects up to 8 external interrupt lines and synchronizes them; they are asynchronous to i_clk.
- Latches rising edges into a pending register, applies a mask and arbitrates by fixed priority.
- Drives the single external-interrupt request into coprocessor 0.
- Sequences request/acknowledge/return so exactly one source is in service between the coprocessor accepting the interrupt and the handler executing eret.
- Exposes MASK, PEND and ID as memory-mapped registers so the handler can identify and clear the source.

Parameters:
N_IRQ, 8, number of interrupt inputs (1..8); bit 0 is highest priority.
ADDR_BASE, 32'h00000080, base byte address of the register window (MASK=+0, PEND=+4, ID=+8).

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_irq  input  N_IRQ  external interrupt lines, asynchronous, rising-edge triggered
i_we  input  1  register write strobe
i_addr  input  32  register byte address
i_data  input  32  register write data
i_ack  input  1  coprocessor 0 accepted the interrupt (its interrupt-taken output)
i_eret  input  1  eret executed
o_data  output  32  register read data, combinational from i_addr
o_int_req  output  1  interrupt request to coprocessor 0 external-interrupt input
o_irq_id  output  3  index of the selected/in-service source
o_busy  output  1  a source is in service (state SERVICE)

Behaviour:
Clock and reset:
- Clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: sync flops 0, edge-history 0, MASK = all ones in bits N_IRQ-1:0, PEND 0, state IDLE, o_irq_id 0, o_int_req 0, o_busy 0.

Input capture:
- Each i_irq bit passes through a 2-flop synchronizer (s1, s2) plus a history flop s3.
- edge[k] = s2[k] & ~s3[k].
- A pulse on i_irq must be high for at least one sampling edge to be captured.

PEND register:
- PEND[k] is set on edge[k].
- PEND is cleared by a write to ADDR_BASE+4 with i_data[k]=1 (write-1-to-clear).
- PEND[k] is also cleared when its request is acknowledged.
- If set and clear hit the same bit in the same cycle, set wins.

Register access:
- Write to ADDR_BASE+0 loads MASK from i_data[N_IRQ-1:0].
- Reads:
  - +0 returns {0, MASK}.
  - +4 returns {0, PEND}.
  - +8 returns {o_busy, 28'b0, o_irq_id} in bits 31 and 2:0.
  - Any other address returns 0.
- The ID register is read-only; writes to +8 are ignored.
- Unused high bits read 0.

Arbitration:
- sel = lowest index k with PEND[k] & MASK[k].
- any = OR of (PEND & MASK).

FSM:
- IDLE:
  - o_int_req=0.
  - If any: o_irq_id <= sel; go REQ.
- REQ:
  - o_int_req=1.
  - If i_ack: clear PEND[o_irq_id]; go SERVICE.
  - Else if (PEND[o_irq_id] & MASK[o_irq_id])=0 (masked or cleared by software): withdraw, go IDLE.
  - A higher-priority source arriving while in REQ does not preempt; o_irq_id is frozen in REQ.
  - i_eret in REQ is ignored.
- SERVICE:
  - o_int_req=0, o_busy=1.
  - New edges still set PEND, but no request is raised.
  - On i_eret go IDLE; o_irq_id holds its value.
  - i_ack in SERVICE is ignored.

Ordering and latency:
- If i_eret and a pending source coincide, go IDLE first; the next request is raised one cycle later, giving one clean low cycle on o_int_req.
- Latency: i_irq rise sampled at edge 0 → s2 high at edge 1 → PEND set at edge 2 → REQ at edge 3 → o_int_req high after edge 3.

Reset mid-operation:
- Reset mid-operation returns everything to reset values immediately.
- An i_irq held high through reset release is captured as an edge once s2 rises (s3 resets low).

Test Plan:
- Reset, read +0/+4/+8 → 0x000000FF, 0x0, 0x0; o_int_req=0.
- Pulse i_irq[3] one cycle, no ack → o_int_req rises after 4th edge; PEND=0x08; ID read =0x3. Then i_ack one cycle → next cycle PEND=0x00, o_busy=1, ID read =0x80000003, o_int_req=0.
- Simultaneous rise of i_irq[5] and i_irq[1] → o_irq_id=1. After ack and eret, request re-raised with o_irq_id=5 after exactly one low cycle on o_int_req.
- MASK write 0xFD, then pulse i_irq[1] → PEND=0x02, no request. Write MASK 0xFF → request with id 1 within 2 cycles.
- In REQ on id 2, write 0x04 to +4 with no ack → o_int_req drops next cycle, state IDLE, PEND=0.
- Same-cycle W1C of bit 4 and new edge[4] → PEND[4] stays 1. Assert i_rst_n low during SERVICE → all outputs 0 asynchronously, MASK=0xFF.
